// File: rtl/imem_loader_if.sv
// Word-stream handshake into the IRAM boot loader.
// The source drives data/valid/last; the loader answers with ready.
interface imem_loader_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: streams an image into IRAM, reads it back against a running checksum,
// then hands the IRAM port to the core by raising core_start.
module imem_loader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_req,
  imem_loader_if.slave      in_if,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic              core_start,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'((2**ADDR_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W:0]     count;
  logic [ADDR_W:0]     rd_cnt;
  logic [ADDR_W:0]     cap_cnt;
  logic [DATA_W-1:0]   wsum;
  logic [DATA_W-1:0]   rsum;
  logic                err;
  logic [RD_LATENCY-1:0] rd_pipe;

  logic xfer;
  logic last_xfer;
  logic capture;
  logic cap_last;
  logic sums_ok;

  assign xfer      = in_if.in_valid & in_if.in_ready;
  assign last_xfer = xfer & (in_if.in_last | (count == LAST_IDX));
  // rd_pipe tracks each issued read until its data appears on mem_q
  assign capture   = rd_pipe[RD_LATENCY-1];
  assign cap_last  = capture & ((cap_cnt + ONE) == count);
  assign sums_ok   = (rsum == wsum) & ~err;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (load_req)  state_nx = S_LOAD;
      S_LOAD:   if (last_xfer) state_nx = S_VERIFY;
      S_VERIFY: if (cap_last)  state_nx = S_CHECK;
      S_CHECK:  state_nx = sums_ok ? S_RUN : S_ERROR;
      S_RUN:    if (load_req)  state_nx = S_LOAD;
      S_ERROR:  if (load_req)  state_nx = S_LOAD;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- state outputs
  always_comb begin
    in_if.in_ready = 1'b0;
    core_start     = 1'b0;
    busy           = 1'b0;
    case (state)
      S_LOAD:   begin in_if.in_ready = 1'b1; busy = 1'b1; end
      S_VERIFY: busy = 1'b1;
      S_CHECK:  busy = 1'b1;
      S_RUN:    core_start = 1'b1;
      default:  ;
    endcase
  end

  assign error      = err;
  assign word_count = count;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      mem_rden <= 1'b0;
      rd_pipe  <= '0;
      count    <= '0;
      rd_cnt   <= '0;
      cap_cnt  <= '0;
      wsum     <= '0;
      rsum     <= '0;
      err      <= 1'b0;
    end else begin
      // the IRAM port idles at zero unless this cycle issues a write or read
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      mem_rden <= 1'b0;

      rd_pipe[0] <= mem_rden;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end

      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (load_req) begin
            count   <= '0;
            rd_cnt  <= '0;
            cap_cnt <= '0;
            wsum    <= '0;
            rsum    <= '0;
            err     <= 1'b0;
          end
        end

        S_LOAD: begin
          if (xfer) begin
            mem_wren <= 1'b1;
            mem_addr <= count[ADDR_W-1:0];
            mem_data <= in_if.in_data;
            wsum     <= wsum + in_if.in_data;
            count    <= count + ONE;
            if ((count == LAST_IDX) && !in_if.in_last) begin
              err <= 1'b1;
            end
          end
        end

        S_VERIFY: begin
          if (rd_cnt != count) begin
            mem_rden <= 1'b1;
            mem_addr <= rd_cnt[ADDR_W-1:0];
            rd_cnt   <= rd_cnt + ONE;
          end
          if (capture) begin
            rsum    <= rsum + mem_q;
            cap_cnt <= cap_cnt + ONE;
          end
        end

        S_CHECK: begin
          if (!sums_ok) begin
            err <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule
